audio_filter_sched: RTL and testbench

//  Shares one audio_filter comb/DC datapath, and its 1024x24 state RAM, between NCH PDM channels.
//  - On each stb_pcm, snapshots all cic_integrator outputs.
//  - Runs the filter once per channel, ch0 first, each channel with its own RAM slot.
//  - Publishes a coherent PCM frame when all channels are done.
//  - Optionally zero-fills the RAM state after reset.

---
 rtl/audio_filter_sched_pkg.sv | 22 ++
 rtl/audio_filter_sched_if.sv | 24 ++
 rtl/audio_filter_sched_clear.sv | 54 +++++
 rtl/audio_filter_sched.sv | 200 ++++++++++++++++++++
 tb/tb_audio_filter_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_filter_sched_pkg.sv
// Shared widths, timeout and scheduler state encoding for audio_filter_sched.
package audio_filter_sched_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 24;
    localparam int PCM_W     = 16;
    localparam int RAM_DEPTH = 1024;
    localparam int BUSY_TMO  = 4;

    typedef enum logic [3:0] {
        WAIT_IDLE = 4'd0,
        IDLE      = 4'd1,
        START     = 4'd2,
        WAIT_HI   = 4'd3,
        WAIT_LO   = 4'd4,
        STORE     = 4'd5,
        NEXT      = 4'd6,
        DONE      = 4'd7,
        CLEAR     = 4'd8
    } sched_state_t;

endpackage

// File: rtl/audio_filter_sched_if.sv
// Handshake and RAM write port between the scheduler (master) and audio_filter (slave).
interface audio_filter_sched_if;
    import audio_filter_sched_pkg::*;

    logic              filt_stb_start;
    logic [ADDR_W-1:0] filt_addr_start;
    logic [DATA_W-1:0] filt_din;
    logic              filt_busy;
    logic [PCM_W-1:0]  filt_out;
    logic              filt_wr_en;
    logic [ADDR_W-1:0] filt_wr_addr;
    logic [DATA_W-1:0] filt_wr_data;

    modport master (
        output filt_stb_start, filt_addr_start, filt_din,
        input  filt_busy, filt_out, filt_wr_en, filt_wr_addr, filt_wr_data
    );

    modport slave (
        input  filt_stb_start, filt_addr_start, filt_din,
        output filt_busy, filt_out, filt_wr_en, filt_wr_addr, filt_wr_data
    );

endinterface

// File: rtl/audio_filter_sched_clear.sv
// audio_sched_clear: walks BASE..BASE+WORDS-1 once after reset, one word per cycle.
// Only compiled when AUDIO_SCHED_CLEAR_EN is defined.
`ifdef AUDIO_SCHED_CLEAR_EN
module audio_sched_clear
    import audio_filter_sched_pkg::*;
#(
    parameter int BASE  = 0,
    parameter int WORDS = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);

    localparam int CNT_W = $clog2(WORDS + 1);

    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    // Remaining-word down-counter; terminal count marks the final write.
    always_comb begin
        rem_d  = rem_q;
        addr_d = addr_q;
        done_d = done_q;
        if (!done_q) begin
            if (rem_q == '0) begin
                done_d = 1'b1;
            end else begin
                rem_d  = rem_q - 1'b1;
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Counter registers, restarted by every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= CNT_W'(WORDS - 1);
            addr_q <= ADDR_W'(BASE);
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            addr_q <= addr_d;
            done_q <= done_d;
        end
    end

    assign last = !done_q && (rem_q == '0);
    assign addr = addr_q;

endmodule
`endif

// File: rtl/audio_filter_sched.sv
// audio_filter_sched: time-shares one audio_filter between NCH channels per PCM frame.
// Optional post-reset RAM zero-fill: define AUDIO_SCHED_CLEAR_EN.
//
// state     | meaning
// CLEAR     | zero-filling the channel RAM slots (AUDIO_SCHED_CLEAR_EN only)
// WAIT_IDLE | filter may still be running from before reset; wait for busy low
// IDLE      | waiting for stb_pcm; snapshot ch_data on it
// START     | one-cycle start pulse for channel ch
// WAIT_HI   | waiting for busy to rise, timeout -> fault and skip channel
// WAIT_LO   | filter running
// STORE     | capture filt_out into the channel shadow register
// NEXT      | advance channel or finish
// DONE      | publish shadow registers as one coherent frame
module audio_filter_sched
    import audio_filter_sched_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int STRIDE = 5,
    parameter int BASE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stb_pcm,
    input  logic [NCH*DATA_W-1:0]   ch_data,
    audio_filter_sched_if.master    filt,
    output logic                    ram_wr_en,
    output logic [ADDR_W-1:0]       ram_wr_addr,
    output logic [DATA_W-1:0]       ram_wr_data,
    output logic [NCH*PCM_W-1:0]    pcm_out,
    output logic                    pcm_valid,
    output logic                    overrun,
    output logic                    fault
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TMO_W = $clog2(BUSY_TMO + 1);
`ifdef AUDIO_SCHED_CLEAR_EN
    localparam sched_state_t RST_STATE = CLEAR;
`else
    localparam sched_state_t RST_STATE = WAIT_IDLE;
`endif

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("audio_filter_sched: NCH must be 1..8");
    end
    if (BASE + NCH * STRIDE > RAM_DEPTH) begin : g_bad_base
        $error("audio_filter_sched: channel slots exceed state RAM");
    end

    sched_state_t              state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [NCH*DATA_W-1:0]     snap_q, snap_d;
    logic [NCH*PCM_W-1:0]      shadow_q, shadow_d;
    logic [NCH*PCM_W-1:0]      pcm_q, pcm_d;
    logic                      pcm_valid_q, pcm_valid_d;
    logic                      overrun_q, overrun_d;
    logic                      fault_q, fault_d;

`ifdef AUDIO_SCHED_CLEAR_EN
    logic              clr_last;
    logic [ADDR_W-1:0] clr_addr;

    audio_sched_clear #(
        .BASE  (BASE),
        .WORDS (NCH * STRIDE)
    ) u_clear (
        .clk  (clk),
        .rst  (rst),
        .last (clr_last),
        .addr (clr_addr)
    );
`endif

    // Next-state, datapath updates and the start/RAM-mux outputs.
    always_comb begin
        state_d             = state_q;
        ch_d                = ch_q;
        addr_d              = addr_q;
        tmo_d               = tmo_q;
        snap_d              = snap_q;
        shadow_d            = shadow_q;
        pcm_d               = pcm_q;
        pcm_valid_d         = 1'b0;
        overrun_d           = overrun_q;
        fault_d             = fault_q;
        filt.filt_stb_start = 1'b0;
        ram_wr_en           = filt.filt_wr_en;
        ram_wr_addr         = filt.filt_wr_addr;
        ram_wr_data         = filt.filt_wr_data;

        // A strobe is only consumed in IDLE; CLEAR swallows it silently.
        if (stb_pcm && state_q != IDLE && state_q != CLEAR) begin
            overrun_d = 1'b1;
        end

        case (state_q)
`ifdef AUDIO_SCHED_CLEAR_EN
            CLEAR: begin
                ram_wr_en   = !rst;
                ram_wr_addr = clr_addr;
                ram_wr_data = '0;
                if (clr_last) begin
                    state_d = WAIT_IDLE;
                end
            end
`endif
            WAIT_IDLE: begin
                if (!filt.filt_busy) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (stb_pcm) begin
                    snap_d  = ch_data;
                    ch_d    = '0;
                    addr_d  = ADDR_W'(BASE);
                    state_d = START;
                end
            end
            START: begin
                filt.filt_stb_start = 1'b1;
                tmo_d               = TMO_W'(BUSY_TMO - 1);
                state_d             = WAIT_HI;
            end
            WAIT_HI: begin
                if (filt.filt_busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_q == '0) begin
                    fault_d = 1'b1;
                    state_d = NEXT;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            WAIT_LO: begin
                if (!filt.filt_busy) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                shadow_d[PCM_W*ch_q +: PCM_W] = filt.filt_out;
                state_d                       = NEXT;
            end
            NEXT: begin
                if (ch_q == CH_W'(NCH - 1)) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    addr_d  = addr_q + ADDR_W'(STRIDE);
                    state_d = START;
                end
            end
            DONE: begin
                pcm_d       = shadow_q;
                pcm_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            ch_q        <= '0;
            addr_q      <= '0;
            tmo_q       <= '0;
            snap_q      <= '0;
            shadow_q    <= '0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            addr_q      <= addr_d;
            tmo_q       <= tmo_d;
            snap_q      <= snap_d;
            shadow_q    <= shadow_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
            fault_q     <= fault_d;
        end
    end

    assign filt.filt_addr_start = addr_q;
    assign filt.filt_din        = snap_q[DATA_W*ch_q +: DATA_W];
    assign pcm_out              = pcm_q;
    assign pcm_valid            = pcm_valid_q;
    assign overrun              = overrun_q;
    assign fault                = fault_q;

endmodule

// File: tb/tb_audio_filter_sched.sv
// Directed bench for audio_filter_sched with a behavioural filter and state RAM.
// Filter model: result = din[23:8] + state[15:0], then state := din.
module tb_audio_filter_sched;
    import audio_filter_sched_pkg::*;

    localparam int NCH = 2;
    localparam int RUN = 6;
    localparam int LAT_OK  = NCH * (RUN + 4) + 2;
    localparam int LAT_TMO = NCH * (BUSY_TMO + 2) + 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  stb_pcm = 1'b0;
    logic [NCH*DATA_W-1:0] ch_data = '0;
    logic                  ram_wr_en;
    logic [ADDR_W-1:0]     ram_wr_addr;
    logic [DATA_W-1:0]     ram_wr_data;
    logic [NCH*PCM_W-1:0]  pcm_out;
    logic                  pcm_valid, overrun, fault;

    audio_filter_sched_if fif ();

    audio_filter_sched #(.NCH(NCH), .STRIDE(5), .BASE(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .stb_pcm     (stb_pcm),
        .ch_data     (ch_data),
        .filt        (fif),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .pcm_out     (pcm_out),
        .pcm_valid   (pcm_valid),
        .overrun     (overrun),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Behavioural audio_filter, deliberately without reset.
    logic              tie_low = 1'b0;
    int                run_cnt = 0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic [DATA_W-1:0] f_din = '0;
    logic [DATA_W-1:0] ram [0:RAM_DEPTH-1];

    initial begin
        fif.filt_busy    = 1'b0;
        fif.filt_out     = '0;
        fif.filt_wr_en   = 1'b0;
        fif.filt_wr_addr = '0;
        fif.filt_wr_data = '0;
    end

    always @(posedge clk) begin
        fif.filt_wr_en <= 1'b0;
        if (!fif.filt_busy) begin
            if (fif.filt_stb_start && !tie_low) begin
                fif.filt_busy <= 1'b1;
                run_cnt       <= RUN - 1;
                f_addr        <= fif.filt_addr_start;
                f_din         <= fif.filt_din;
            end
        end else if (run_cnt == 0) begin
            fif.filt_busy    <= 1'b0;
            fif.filt_out     <= f_din[23:8] + ram[f_addr][15:0];
            fif.filt_wr_en   <= 1'b1;
            fif.filt_wr_addr <= f_addr;
            fif.filt_wr_data <= f_din;
        end else begin
            run_cnt <= run_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    end

    // Monitor sampled on the falling edge.
    logic [ADDR_W-1:0] st_addr [$];
    logic [DATA_W-1:0] st_din  [$];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];
    int n_valid = 0;
    int start_while_busy = 0;

    always @(negedge clk) begin
        if (fif.filt_stb_start) begin
            st_addr.push_back(fif.filt_addr_start);
            st_din.push_back(fif.filt_din);
            if (fif.filt_busy) start_while_busy++;
        end
        if (pcm_valid) n_valid++;
        if (ram_wr_en && !rst) begin
            wr_addr_q.push_back(ram_wr_addr);
            wr_data_q.push_back(ram_wr_data);
        end
    end

    logic f5, f6;

    task automatic do_frame(input string tag, input logic [23:0] d0, input logic [23:0] d1,
                            input int inj, input int exp_lat, input logic [31:0] exp_pcm);
        int   lat = 0;
        int   nv0 = n_valid;
        int   ns0 = st_addr.size();
        logic seen = 1'b0;
        ch_data = {d1, d0};
        @(negedge clk);
        stb_pcm = 1'b1;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            stb_pcm = (lat == inj);
            ch_data = {~d1, ~d0};
            if (lat == 5) f5 = fault;
            if (lat == 6) f6 = fault;
            if (pcm_valid) seen = 1'b1;
        end
        stb_pcm = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_pcm_out"}, pcm_out, exp_pcm);
        repeat (3) @(negedge clk);
        chk({tag, "_valid_cnt"}, n_valid - nv0, 1);
        chk({tag, "_start_cnt"}, st_addr.size() - ns0, 2);
        if (st_addr.size() >= ns0 + 2) begin
            chk({tag, "_addr0"}, 32'(st_addr[ns0]), 0);
            chk({tag, "_addr1"}, 32'(st_addr[ns0+1]), 5);
            chk({tag, "_din0"}, 32'(st_din[ns0]), 32'(d0));
            chk({tag, "_din1"}, 32'(st_din[ns0+1]), 32'(d1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns_rst;
        int bound;
        for (int i = 0; i < RAM_DEPTH; i++) begin
`ifdef AUDIO_SCHED_CLEAR_EN
            ram[i] = 24'hABCDEF;
`else
            ram[i] = 24'h000000;
`endif
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pcm_out", pcm_out, 0);
        chk("rst_pcm_valid", pcm_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_fault", fault, 0);
        chk("rst_start", fif.filt_stb_start, 0);
        chk("rst_addr", fif.filt_addr_start, 0);
        chk("rst_din", fif.filt_din, 0);
        chk("rst_ram_wr_en", ram_wr_en, 0);
        rst = 1'b0;

`ifdef AUDIO_SCHED_CLEAR_EN
        repeat (2) @(negedge clk);
        stb_pcm = 1'b1;
        repeat (3) @(negedge clk);
        stb_pcm = 1'b0;
        repeat (20) @(negedge clk);
        chk("clr_wr_cnt", wr_addr_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < wr_addr_q.size()) begin
                chk("clr_wr_addr", 32'(wr_addr_q[i]), i);
                chk("clr_wr_data", 32'(wr_data_q[i]), 0);
            end
            chk("clr_ram_word", 32'(ram[i]), 0);
        end
        chk("clr_ram_10_kept", 32'(ram[10]), 32'hABCDEF);
        chk("clr_overrun", overrun, 0);
        chk("clr_no_start", st_addr.size(), 0);
        chk("clr_no_valid", n_valid, 0);
`else
        repeat (5) @(negedge clk);
`endif

        // Frame 1: state 0 -> results are din[23:8].
        do_frame("f1", 24'h000100, 24'hFFFF00, 0, LAT_OK, 32'hFFFF_0001);
        chk("f1_overrun", overrun, 0);
        chk("f1_fault", fault, 0);

        // Frame 2 with a second strobe during WAIT_LO of ch0.
        do_frame("f2", 24'h123456, 24'h00AB00, 5, LAT_OK, 32'hFFAB_1334);
        chk("f2_overrun", overrun, 1);
        chk("f2_fault", fault, 0);

        do_frame("f3", 24'h000200, 24'h000300, 0, LAT_OK, 32'hAB03_3458);
        chk("f3_overrun_sticky", overrun, 1);

        // Frame 4: busy never rises; both channels time out, frame unchanged.
        tie_low = 1'b1;
        do_frame("f4", 24'h777700, 24'h888800, 0, LAT_TMO, 32'hAB03_3458);
        tie_low = 1'b0;
        chk("f4_fault_early", f5, 0);
        chk("f4_fault_at_tmo", f6, 1);
        chk("f4_fault", fault, 1);

        // Reset while ch0 of a frame is being filtered.
        ch_data = {24'h000500, 24'h000400};
        @(negedge clk);
        stb_pcm = 1'b1;
        @(negedge clk);
        stb_pcm = 1'b0;
        bound = 0;
        while (!fif.filt_busy && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        chk("r_busy_seen", fif.filt_busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ns_rst = st_addr.size();
        chk("r_pcm_out", pcm_out, 0);
        chk("r_overrun", overrun, 0);
        chk("r_fault", fault, 0);
        chk("r_pcm_valid", pcm_valid, 0);
        chk("r_busy_still", fif.filt_busy, 1);
        bound = 0;
        while (fif.filt_busy && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        chk("r_busy_fell", fif.filt_busy, 0);
        chk("r_no_start_busy", st_addr.size() - ns_rst, 0);
        repeat (15) @(negedge clk);
        chk("r_no_start_idle", st_addr.size() - ns_rst, 0);
        chk("r_start_while_busy", start_while_busy, 0);

`ifdef AUDIO_SCHED_CLEAR_EN
        // The second clear wiped the slots, including the late ch0 write.
        do_frame("f6", 24'h001000, 24'h002000, 0, LAT_OK, 32'h0020_0010);
`else
        // Interrupted ch0 still wrote 000400; ch1 kept 000300.
        do_frame("f6", 24'h001000, 24'h002000, 0, LAT_OK, 32'h0320_0410);
`endif
        chk("f6_overrun", overrun, 0);
        chk("f6_fault", fault, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
